// File: rtl/dpc_pkg.sv
// Shared constants, write-FSM encoding and host word packing for the DPC bad-pixel list.
package dpc_pkg;
  localparam int CNT_WIDTH      = 10;
  localparam int AUTO_BP_NUM    = 256;
  localparam int AUTO_BP_BIT    = 8;
  localparam int DROP_CNT_WIDTH = 16;

  typedef enum logic {
    W_IDLE    = 1'b0,
    W_COLLECT = 1'b1
  } wstate_t;

  // Stored entry is {y,x}; the host sees each coordinate zero-extended into a 16-bit half.
  function automatic logic [31:0] pack_rd_data(input logic [2*CNT_WIDTH-1:0] entry);
    logic [31:0] word;
    word                          = '0;
    word[CNT_WIDTH-1:0]           = entry[CNT_WIDTH-1:0];
    word[16 +: CNT_WIDTH]         = entry[2*CNT_WIDTH-1:CNT_WIDTH];
    return word;
  endfunction
endpackage

// File: rtl/dpc_bp_list_ram.sv
// Simple dual-port RAM holding both list banks; bank select is the address MSB.
module dpc_bp_list_ram #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: storage has no reset so it maps onto block RAM; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dpc_bp_list_ctrl.sv
// Ping-pong collector of per-frame bad-pixel coordinates with host random-access readout.
module dpc_bp_list_ctrl #(
  parameter int CNT_WIDTH      = dpc_pkg::CNT_WIDTH,
  parameter int AUTO_BP_NUM    = dpc_pkg::AUTO_BP_NUM,
  parameter int AUTO_BP_BIT    = dpc_pkg::AUTO_BP_BIT,
  parameter int DROP_CNT_WIDTH = dpc_pkg::DROP_CNT_WIDTH
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      enable,
  input  logic                      det_valid,
  input  logic                      det_bp,
  input  logic [CNT_WIDTH-1:0]      det_x,
  input  logic [CNT_WIDTH-1:0]      det_y,
  input  logic                      frame_done,
  input  logic                      host_rd_en,
  input  logic [AUTO_BP_BIT-1:0]    host_rd_addr,
  input  logic                      host_release,
  output logic                      host_rd_valid,
  output logic [31:0]               host_rd_data,
  output logic                      list_ready,
  output logic [AUTO_BP_BIT:0]      list_count,
  output logic                      list_overflow,
  output logic                      list_irq,
  output logic [DROP_CNT_WIDTH-1:0] frames_dropped
);
  import dpc_pkg::*;

  wstate_t                  state;
  logic                     wr_bank, rd_bank;
  logic [AUTO_BP_BIT:0]     wr_cnt;
  logic                     wr_ovf;
  logic                     rd_hit;
  logic [2*CNT_WIDTH-1:0]   ram_q;

  logic                     det_hit, wr_full, wr_en, ready_eff, final_ovf;
  logic [AUTO_BP_BIT:0]     final_cnt;

  // AUTO_BP_NUM is a power of two, so the counter MSB alone marks a full bank.
  assign det_hit   = det_valid & det_bp & enable;
  assign wr_full   = wr_cnt[AUTO_BP_BIT];
  assign wr_en     = (state == W_COLLECT) & det_hit & ~wr_full;
  assign final_cnt = wr_cnt + {{AUTO_BP_BIT{1'b0}}, wr_en};
  assign final_ovf = wr_ovf | (det_hit & wr_full);
  // A release in the same cycle as frame_done frees the read bank before the close decision.
  assign ready_eff = list_ready & ~host_release;

  dpc_bp_list_ram #(
    .DATA_W (2*CNT_WIDTH),
    .ADDR_W (AUTO_BP_BIT+1)
  ) u_ram (
    .clk   (aclk),
    .we    (wr_en),
    .waddr ({wr_bank, wr_cnt[AUTO_BP_BIT-1:0]}),
    .wdata ({det_y, det_x}),
    .re    (host_rd_en),
    .raddr ({rd_bank, host_rd_addr}),
    .rdata (ram_q)
  );

  assign host_rd_data = rd_hit ? pack_rd_data(ram_q) : 32'd0;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= W_IDLE;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      wr_cnt         <= '0;
      wr_ovf         <= 1'b0;
      list_ready     <= 1'b0;
      list_count     <= '0;
      list_overflow  <= 1'b0;
      list_irq       <= 1'b0;
      frames_dropped <= '0;
      host_rd_valid  <= 1'b0;
      rd_hit         <= 1'b0;
    end else begin
      list_irq      <= 1'b0;
      host_rd_valid <= host_rd_en;
      rd_hit        <= host_rd_en & list_ready & ({1'b0, host_rd_addr} < list_count);
      if (host_release) list_ready <= 1'b0;

      case (state)
        W_IDLE: begin
          if (frame_done && enable) begin
            state  <= W_COLLECT;
            wr_cnt <= '0;
            wr_ovf <= 1'b0;
          end
        end
        W_COLLECT: begin
          if (!enable) begin
            state  <= W_IDLE;
            wr_cnt <= '0;
            wr_ovf <= 1'b0;
          end else if (frame_done) begin
            wr_cnt <= '0;
            wr_ovf <= 1'b0;
            if (!ready_eff) begin
              rd_bank       <= wr_bank;
              wr_bank       <= ~wr_bank;
              list_count    <= final_cnt;
              list_overflow <= final_ovf;
              list_ready    <= 1'b1;
              list_irq      <= 1'b1;
            end else if (~&frames_dropped) begin
              frames_dropped <= frames_dropped + 1'b1;
            end
          end else begin
            if (wr_en) wr_cnt <= wr_cnt + 1'b1;
            if (det_hit && wr_full) wr_ovf <= 1'b1;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dpc_bp_list_ctrl.sv
// Directed self-checking bench for the ping-pong bad-pixel list controller.
module tb_dpc_bp_list_ctrl;
  logic        aclk = 1'b0;
  logic        areset;
  logic        enable, det_valid, det_bp, frame_done;
  logic [9:0]  det_x, det_y;
  logic        host_rd_en, host_release;
  logic [7:0]  host_rd_addr;
  logic        host_rd_valid;
  logic [31:0] host_rd_data;
  logic        list_ready, list_overflow, list_irq;
  logic [8:0]  list_count;
  logic [15:0] frames_dropped;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  dpc_bp_list_ctrl dut (
    .aclk           (aclk),
    .areset         (areset),
    .enable         (enable),
    .det_valid      (det_valid),
    .det_bp         (det_bp),
    .det_x          (det_x),
    .det_y          (det_y),
    .frame_done     (frame_done),
    .host_rd_en     (host_rd_en),
    .host_rd_addr   (host_rd_addr),
    .host_release   (host_release),
    .host_rd_valid  (host_rd_valid),
    .host_rd_data   (host_rd_data),
    .list_ready     (list_ready),
    .list_count     (list_count),
    .list_overflow  (list_overflow),
    .list_irq       (list_irq),
    .frames_dropped (frames_dropped)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int x, input int y);
    return (32'(y) << 16) | 32'(x);
  endfunction

  task automatic cyc();
    @(negedge aclk);
  endtask

  task automatic det(input int x, input int y);
    det_valid = 1'b1; det_bp = 1'b1; det_x = 10'(x); det_y = 10'(y);
    cyc();
    det_valid = 1'b0; det_bp = 1'b0;
  endtask

  task automatic fdone();
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
  endtask

  task automatic rel();
    host_release = 1'b1;
    cyc();
    host_release = 1'b0;
  endtask

  task automatic rd(input string tag, input int addr, input logic [31:0] exp);
    host_rd_en = 1'b1; host_rd_addr = 8'(addr);
    cyc();
    host_rd_en = 1'b0;
    check({tag, "_valid"}, 32'(host_rd_valid), 32'd1);
    check(tag, host_rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    areset = 1'b1; enable = 1'b0; det_valid = 1'b0; det_bp = 1'b0;
    det_x = '0; det_y = '0; frame_done = 1'b0;
    host_rd_en = 1'b0; host_rd_addr = '0; host_release = 1'b0;
    cyc(); cyc();
    check("rst_ready", 32'(list_ready), 32'd0);
    check("rst_count", 32'(list_count), 32'd0);
    check("rst_valid", 32'(host_rd_valid), 32'd0);
    check("rst_data", host_rd_data, 32'd0);
    areset = 1'b0;
    enable = 1'b1;

    // Basic frame: arm, three detections plus one unflagged pixel, close
    fdone();
    det(5, 2);
    det_valid = 1'b1; det_bp = 1'b0; det_x = 10'd7; det_y = 10'd7;
    cyc();
    det_valid = 1'b0;
    det(639, 0);
    det(0, 511);
    check("pre_ready", 32'(list_ready), 32'd0);
    fdone();
    check("pub_ready", 32'(list_ready), 32'd1);
    check("pub_irq", 32'(list_irq), 32'd1);
    check("pub_count", 32'(list_count), 32'd3);
    check("pub_ovf", 32'(list_overflow), 32'd0);
    cyc();
    check("irq_pulse", 32'(list_irq), 32'd0);
    check("idle_valid", 32'(host_rd_valid), 32'd0);
    // Back-to-back reads of entries 0 and 1
    host_rd_en = 1'b1; host_rd_addr = 8'd0;
    cyc();
    check("b2b_v0", 32'(host_rd_valid), 32'd1);
    check("b2b_d0", host_rd_data, word(5, 2));
    host_rd_addr = 8'd1;
    cyc();
    host_rd_en = 1'b0;
    check("b2b_v1", 32'(host_rd_valid), 32'd1);
    check("b2b_d1", host_rd_data, word(639, 0));
    rd("rd2", 2, word(0, 511));
    rd("rd3_oob", 3, 32'd0);

    // Overflow frame
    rel();
    check("rel_ready", 32'(list_ready), 32'd0);
    check("rel_count", 32'(list_count), 32'd3);
    rd("rd_unpub", 0, 32'd0);
    for (int i = 0; i < 300; i++) det(i, i + 1);
    fdone();
    check("ovf_ready", 32'(list_ready), 32'd1);
    check("ovf_count", 32'(list_count), 32'd256);
    check("ovf_flag", 32'(list_overflow), 32'd1);
    rd("ovf_rd255", 255, word(255, 256));
    rd("ovf_rd0", 0, word(0, 1));

    // Two dropped frames while the host still holds the list
    det(1, 1); fdone();
    det(2, 2); fdone();
    check("drop_cnt", 32'(frames_dropped), 32'd2);
    check("drop_count", 32'(list_count), 32'd256);
    check("drop_ovf", 32'(list_overflow), 32'd1);
    rd("drop_rd255", 255, word(255, 256));

    // Release, then the next frame publishes
    rel();
    det(20, 21); det(22, 23);
    fdone();
    check("rep_ready", 32'(list_ready), 32'd1);
    check("rep_count", 32'(list_count), 32'd2);
    check("rep_ovf", 32'(list_overflow), 32'd0);
    rd("rep_rd1", 1, word(22, 23));

    // Detection, frame_done and release all in one cycle
    det(7, 8);
    det_valid = 1'b1; det_bp = 1'b1; det_x = 10'd9; det_y = 10'd10;
    frame_done = 1'b1; host_release = 1'b1;
    cyc();
    det_valid = 1'b0; det_bp = 1'b0; frame_done = 1'b0; host_release = 1'b0;
    check("coin_ready", 32'(list_ready), 32'd1);
    check("coin_count", 32'(list_count), 32'd2);
    check("coin_drop", 32'(frames_dropped), 32'd2);
    rd("coin_rd0", 0, word(7, 8));
    rd("coin_rd1", 1, word(9, 10));

    // enable drops mid-frame: the following frame_done only re-arms
    rel();
    det(1, 2);
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    det(3, 4);
    fdone();
    check("en_nopub", 32'(list_ready), 32'd0);
    det(11, 12); det(13, 14); det(15, 16);
    fdone();
    check("en_pub", 32'(list_ready), 32'd1);
    check("en_count", 32'(list_count), 32'd3);
    rd("en_rd2", 2, word(15, 16));

    // Asynchronous reset mid-frame with a published list
    det(30, 31);
    #2 areset = 1'b1;
    #1;
    check("ar_ready", 32'(list_ready), 32'd0);
    check("ar_count", 32'(list_count), 32'd0);
    check("ar_drop", 32'(frames_dropped), 32'd0);
    cyc();
    areset = 1'b0;
    det(40, 41);
    fdone();
    check("ar_arm", 32'(list_ready), 32'd0);
    det(50, 51);
    fdone();
    check("ar_pub", 32'(list_ready), 32'd1);
    check("ar_pcount", 32'(list_count), 32'd1);
    rd("ar_rd0", 0, word(50, 51));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/dpc_bp_list_ctrl.md
Name: dpc_bp_list_ctrl

Overview:
Ping-pong list controller for per-frame auto-detected bad-pixel coordinates produced by the DPC detector. It collects the flagged (x,y) pairs of one whole frame into a write bank and publishes the finished list to the host by swapping banks at frame end. It serves host random-access reads of the published list. A new frame is dropped, never mixed, while the host still holds the previous list.

Parameters:
CNT_WIDTH, 10, coordinate width
AUTO_BP_NUM, 256, max entries per bank
AUTO_BP_BIT, 8, log2(AUTO_BP_NUM)
DROP_CNT_WIDTH, 16, dropped-frame counter width

Ports:
aclk  in  1  clock
areset  in  1  reset, asynchronous, active-high
enable  in  1  collection enable
det_valid  in  1  detector output strobe, one per pixel position
det_bp  in  1  pixel flagged bad (qualified by det_valid)
det_x  in  CNT_WIDTH  column of flagged pixel
det_y  in  CNT_WIDTH  row of flagged pixel
frame_done  in  1  single-cycle end-of-frame pulse from detector
host_rd_en  in  1  host read strobe
host_rd_addr  in  AUTO_BP_BIT  entry index in published list
host_release  in  1  host finished with published list (pulse)
host_rd_valid  out  1  read data valid
host_rd_data  out  32  {6'b0,y,6'b0,x} for CNT_WIDTH=10; zero-extended per half otherwise
list_ready  out  1  published list available
list_count  out  AUTO_BP_BIT+1  entries in published list (0..AUTO_BP_NUM)
list_overflow  out  1  published frame exceeded AUTO_BP_NUM
list_irq  out  1  one-cycle pulse when list_ready rises
frames_dropped  out  DROP_CNT_WIDTH  saturating count of dropped frames

Behaviour:
- Reset (async, active-high): all outputs 0; both banks empty; write FSM W_IDLE; wr_bank=0; RAM contents are don't-care.
- Write FSM, W_IDLE -> W_COLLECT: on frame_done with enable=1. Guarantees collection starts on a frame boundary.
- W_COLLECT:
  - det_valid & det_bp & enable & wr_cnt<AUTO_BP_NUM: write {y,x} at wr_cnt, wr_cnt++.
  - At wr_cnt==AUTO_BP_NUM: write suppressed; wr_ovf sticky set.
  - enable=0: -> W_IDLE, wr_cnt=0, wr_ovf=0; the partial frame is discarded.
- Frame close (frame_done in W_COLLECT):
  - A detection in the same cycle as frame_done belongs to the closing frame, and is included in the count.
  - If list_ready=0: swap. rd_bank<=wr_bank, wr_bank flips, list_count<=final count, list_overflow<=final ovf, list_ready<=1, list_irq pulses next cycle. The new wr bank starts at wr_cnt=0, ovf=0.
  - If list_ready=1: frame dropped. wr_cnt=0, wr_ovf=0, same bank reused, frames_dropped++ (saturates at all-ones).
  - A zero-entry frame still publishes: list_ready=1, list_count=0.
- host_release:
  - When list_ready=1: list_ready<=0, list_count and list_overflow unchanged until the next publish.
  - Ignored when list_ready=0.
  - Release and frame_done in the same cycle: release applies first, so the frame publishes (no drop).
- Host read: host_rd_en at cycle N -> host_rd_valid=1 at N+1.
  - host_rd_data = rd_bank[host_rd_addr] if list_ready & addr<list_count, else 0; host_rd_valid still 1.
  - Reads are back-to-back capable, one per cycle.
  - Reads never stall writes: dedicated ports on separate banks.
- list_irq: registered rising edge of list_ready.
- The controller never backpressures the detector; det_valid is always accepted.

Decomposition:
- Shared package dpc_pkg: CNT_WIDTH, AUTO_BP_NUM/AUTO_BP_BIT defaults, host_rd_data packing function, write-FSM state encoding (W_IDLE, W_COLLECT).
- Sub-module dpc_bp_list_ram: simple dual-port RAM, depth 2*AUTO_BP_NUM, width 2*CNT_WIDTH, bank bit as address MSB, 1-cycle registered read, no reset on storage.

Test Plan:
- Reset, enable=1, frame_done, then 3 detections (5,2),(639,0),(0,511), then frame_done -> list_ready=1, list_irq one pulse, list_count=3; reads 0..2 return the pairs in order with 1-cycle latency; read addr 3 -> data 0.
- 300 detections in one frame -> list_count=256, list_overflow=1, entry 255 = 256th detection.
- No release; two more frames close -> frames_dropped=2, published list unchanged. Release, next frame closes -> new list published with correct count.
- Detection coincident with frame_done, plus host_release in the same cycle -> that detection is included in the count; publish occurs with no drop.
- enable drops mid-frame, rises, then the frame ends -> nothing published at that frame_done (W_IDLE entered). The next full frame publishes.
- areset asserted mid-frame with list_ready=1 -> all outputs 0 immediately (async). First frame_done after release of reset only arms collection.
